fetch_queue: RTL

FETCH_QUEUE -- requirements
Module: fetch_queue

---
 rtl/fetch_queue.sv | 112 +++++++++++
 1 files changed

// File: rtl/fetch_queue.sv
// Instruction fetch queue: issues fetch addresses to a 1-cycle-latency instruction
// memory and buffers the returned words, tagged with their PC, until decode takes them.
module fetch_queue #(
  parameter int ADDR_W = 32,
  parameter int INST_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     v_i,
  input  logic [ADDR_W-1:0]        addr_i,
  output logic                     stall_o,
  input  logic                     flush_i,
  output logic                     imem_en_o,
  output logic [ADDR_W-1:0]        imem_addr_o,
  input  logic [INST_W-1:0]        imem_data_i,
  output logic                     inst_v_o,
  output logic [INST_W-1:0]        inst_o,
  output logic [ADDR_W-1:0]        pc_o,
  input  logic                     inst_rdy_i,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [INST_W-1:0] instMem_q [DEPTH];
  logic [ADDR_W-1:0] pcMem_q   [DEPTH];

  logic [PW-1:0]     head_q, head_d;
  logic [PW-1:0]     tail_q, tail_d;
  logic [CW-1:0]     count_q, count_d;
  logic              pend_q, pend_d;
  logic [ADDR_W-1:0] pend_pc_q, pend_pc_d;

  logic              issue;
  logic              fill;
  logic              pop;
  logic [CW:0]       occupancy;

  // The in-flight read reserves a slot, so stall depends only on registered state.
  assign occupancy   = {1'b0, count_q} + {{CW{1'b0}}, pend_q};
  assign stall_o     = occupancy >= (CW+1)'(DEPTH);

  assign issue       = v_i & ~stall_o & ~flush_i;
  assign imem_en_o   = issue;
  assign imem_addr_o = addr_i;

  assign fill        = pend_q & ~flush_i;
  assign inst_v_o    = (count_q != '0) & ~flush_i;
  assign pop         = inst_v_o & inst_rdy_i;

  assign inst_o      = instMem_q[head_q];
  assign pc_o        = pcMem_q[head_q];
  assign count_o     = count_q;

  always_comb begin
    head_d    = head_q;
    tail_d    = tail_q;
    count_d   = count_q;
    pend_d    = issue;
    pend_pc_d = pend_pc_q;

    if (issue) begin
      pend_pc_d = addr_i;
    end
    if (pop) begin
      head_d = head_q + PW'(1);
    end
    if (fill) begin
      tail_d = tail_q + PW'(1);
    end
    case ({fill, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    // A flush drops everything, including a response still on its way back.
    if (flush_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
      pend_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      pend_q    <= 1'b0;
      pend_pc_q <= '0;
    end else begin
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      pend_q    <= pend_d;
      pend_pc_q <= pend_pc_d;
    end
  end

  // Storage is not reset; only the pointers and count decide what is valid.
  always_ff @(posedge clk) begin
    if (rst && fill) begin
      instMem_q[tail_q] <= imem_data_i;
      pcMem_q[tail_q]   <= pend_pc_q;
    end
  end

endmodule
